// File: rtl/if_prefetch.sv
// if_prefetch: owns the fetch PC, drives a req/gnt/rvalid instruction port and buffers responses in a DEPTH-entry queue.
// Optional macro IF_JAL_PREDICT_EN: follow JAL targets at fetch time and tag those entries as predicted.
module if_prefetch #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_if,
  input  logic             bubble_if,
  input  logic             pc_src,
  input  logic [WIDTH-1:0] pc_new,
  output logic             instr_req,
  output logic [WIDTH-1:0] instr_addr,
  input  logic             instr_gnt,
  input  logic             instr_rvalid,
  input  logic [WIDTH-1:0] instr_rdata,
  output logic             valid_if,
  output logic [WIDTH-1:0] instr_if,
  output logic [WIDTH-1:0] pc_if,
  output logic [WIDTH-1:0] pc_plus4_if,
  output logic             pred_taken_if
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RESP    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] fetch_pc_reg;
  logic [WIDTH-1:0] resp_pc_reg;
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;

  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [WIDTH-1:0] instr_mem [DEPTH];

  logic             empty;
  logic             push;
  logic             pop;
  logic             room_next;
  logic             pred_hit;
  logic [WIDTH-1:0] redirect_pc;
  logic [WIDTH-1:0] next_seq_pc;
  logic             unused_pc_new_lsbs;

  assign empty       = (count_reg == '0);
  assign valid_if    = !empty && !bubble_if && !pc_src;
  assign pop         = valid_if && !stall_if;
  // A response landing on the redirect cycle belongs to the wrong path.
  assign push        = (state_reg == RESP) && instr_rvalid && !pc_src;
  assign redirect_pc = {pc_new[WIDTH-1:2], 2'b00};
  assign unused_pc_new_lsbs = ^pc_new[1:0];

  always_comb begin
    count_next = count_reg;
    if (pc_src) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (!push && pop) begin
      count_next = count_reg - 1'b1;
    end
  end

  // A new request only issues when a slot is guaranteed for its response.
  assign room_next = (count_next < DEPTH_C);

`ifdef IF_JAL_PREDICT_EN
  logic             pred_mem [DEPTH];
  logic [20:0]      j_imm;
  logic [WIDTH-1:0] jal_target;

  assign j_imm      = {instr_rdata[31], instr_rdata[19:12], instr_rdata[20],
                       instr_rdata[30:21], 1'b0};
  assign jal_target = resp_pc_reg + {{(WIDTH-21){j_imm[20]}}, j_imm};
  assign pred_hit   = push && (instr_rdata[6:0] == 7'b1101111);
  assign next_seq_pc = pred_hit ? jal_target : fetch_pc_reg;

  always_ff @(posedge clk) begin
    if (push) begin
      pred_mem[tail_reg] <= pred_hit;
    end
  end

  assign pred_taken_if = empty ? 1'b0 : pred_mem[head_reg];
`else
  assign pred_hit      = 1'b0;
  assign next_seq_pc   = fetch_pc_reg;
  assign pred_taken_if = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_reg]    <= resp_pc_reg;
      instr_mem[tail_reg] <= instr_rdata;
    end
  end

  assign instr_if    = empty ? '0 : instr_mem[head_reg];
  assign pc_if       = empty ? '0 : pc_mem[head_reg];
  assign pc_plus4_if = empty ? '0 : pc_mem[head_reg] + WIDTH'(4);

  assign instr_req  = (state_reg == REQ);
  assign instr_addr = fetch_pc_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      resp_pc_reg  <= '0;
      head_reg     <= '0;
      tail_reg     <= '0;
      count_reg    <= '0;
    end else begin
      count_reg <= count_next;

      if (pc_src) begin
        head_reg <= '0;
        tail_reg <= '0;
      end else begin
        if (push) tail_reg <= tail_reg + 1'b1;
        if (pop)  head_reg <= head_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (room_next) state_reg <= REQ;
        end
        REQ: begin
          if (instr_gnt) begin
            resp_pc_reg  <= fetch_pc_reg;
            fetch_pc_reg <= fetch_pc_reg + WIDTH'(4);
            state_reg    <= pc_src ? DISCARD : RESP;
          end
        end
        RESP: begin
          if (pc_src) begin
            // If the data arrives with the redirect the transaction is already closed.
            state_reg <= instr_rvalid ? REQ : DISCARD;
          end else if (instr_rvalid) begin
            fetch_pc_reg <= next_seq_pc;
            state_reg    <= room_next ? REQ : IDLE;
          end
        end
        DISCARD: begin
          if (instr_rvalid) state_reg <= REQ;
        end
        default: state_reg <= IDLE;
      endcase

      if (pc_src) begin
        fetch_pc_reg <= redirect_pc;
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch: reset, stall fill/drain, redirects in RESP and REQ, bubble, wrap, JAL prediction.
module tb_if_prefetch;

  logic        clk;
  logic        rst;
  logic        stall_if;
  logic        bubble_if;
  logic        pc_src;
  logic [31:0] pc_new;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        valid_if;
  logic [31:0] instr_if;
  logic [31:0] pc_if;
  logic [31:0] pc_plus4_if;
  logic        pred_taken_if;

  int n_checks = 0;
  int n_errors = 0;

  logic        gnt_en;
  int          lat;
  logic        pend;
  int          pend_wait;
  logic [31:0] pend_addr;

  if_prefetch #(
    .WIDTH(32),
    .DEPTH(4),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_if(stall_if),
    .bubble_if(bubble_if),
    .pc_src(pc_src),
    .pc_new(pc_new),
    .instr_req(instr_req),
    .instr_addr(instr_addr),
    .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid),
    .instr_rdata(instr_rdata),
    .valid_if(valid_if),
    .instr_if(instr_if),
    .pc_if(pc_if),
    .pc_plus4_if(pc_plus4_if),
    .pred_taken_if(pred_taken_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h40) return 32'h0100_006F;
    return {a[15:0], 16'h0013};
  endfunction

  // Memory model: a grant seen in a cycle yields rvalid lat cycles later.
  initial begin
    instr_gnt    = 1'b0;
    instr_rvalid = 1'b0;
    instr_rdata  = '0;
    pend         = 1'b0;
    pend_wait    = 0;
    pend_addr    = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend = 1'b0;
      end else if (instr_req && instr_gnt) begin
        pend      = 1'b1;
        pend_wait = lat;
        pend_addr = instr_addr;
      end
      @(posedge clk);
      #1;
      instr_rvalid = 1'b0;
      if (pend) begin
        pend_wait--;
        if (pend_wait == 0) begin
          instr_rvalid = 1'b1;
          instr_rdata  = mem_word(pend_addr);
          pend         = 1'b0;
        end
      end
      instr_gnt = gnt_en;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%08h", tag, got);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!valid_if && n < max_cyc) begin
      step();
      #1;
      n++;
    end
    check({tag, "_arrives"}, {31'b0, valid_if}, 32'd1);
  endtask

  // Reset, then redirect while REQ waits without a grant; returns on the cycle the new address is presented.
  task automatic start_at(input logic [31:0] pc);
    gnt_en = 1'b0;
    do_reset();
    step();
    pc_src = 1'b1;
    pc_new = pc;
    gnt_en = 1'b1;
    step();
    pc_src = 1'b0;
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc [5];
    logic        req_seen;
    exp_pc = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};

    rst       = 1'b0;
    stall_if  = 1'b1;
    bubble_if = 1'b0;
    pc_src    = 1'b0;
    pc_new    = '0;
    gnt_en    = 1'b1;
    lat       = 1;

    repeat (2) step();
    check("rst_req",      {31'b0, instr_req},     32'd0);
    check("rst_valid",    {31'b0, valid_if},      32'd0);
    check("rst_instr",    instr_if,               32'd0);
    check("rst_pc",       pc_if,                  32'd0);
    check("rst_pc4",      pc_plus4_if,            32'd0);
    check("rst_pred",     {31'b0, pred_taken_if}, 32'd0);

    // First fetch and latency, with the queue held by stall.
    rst = 1'b1;
    step();
    check("t1_req",       {31'b0, instr_req},     32'd1);
    check("t1_addr",      instr_addr,             32'h0);
    step();
    check("t1_resp_valid", {31'b0, valid_if},     32'd0);
    check("t1_resp_req",  {31'b0, instr_req},     32'd0);
    step();
    check("t1_valid",     {31'b0, valid_if},      32'd1);
    check("t1_pc",        pc_if,                  32'h0);
    check("t1_pc4",       pc_plus4_if,            32'h4);
    check("t1_instr",     instr_if,               32'h0000_0013);

    // Queue fills to DEPTH and requests stop.
    repeat (6) step();
    req_seen = 1'b0;
    for (int i = 0; i < 11; i++) begin
      step();
      if (instr_req) req_seen = 1'b1;
    end
    check("full_no_req",  {31'b0, req_seen},      32'd0);
    check("full_head",    pc_if,                  32'h0);

    stall_if = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      check($sformatf("drain%0d_valid", i), {31'b0, valid_if}, 32'd1);
      check($sformatf("drain%0d_pc", i),    pc_if,             exp_pc[i]);
    end
    stall_if = 1'b1;

    // Redirect while waiting in RESP: outstanding response is discarded.
    lat = 2;
    gnt_en = 1'b1;
    do_reset();
    step();
    step();
    pc_src = 1'b1;
    pc_new = 32'h103;
    #1;
    check("rd_resp_valid", {31'b0, valid_if},     32'd0);
    step();
    pc_src = 1'b0;
    #1;
    check("rd_discard_req", {31'b0, instr_req},   32'd0);
    step();
    check("rd_new_req",   {31'b0, instr_req},     32'd1);
    check("rd_new_addr",  instr_addr,             32'h100);
    check("rd_no_stale",  {31'b0, valid_if},      32'd0);
    wait_valid("rd", 10);
    check("rd_first_pc",  pc_if,                  32'h100);
    check("rd_first_instr", instr_if,             32'h0100_0013);
    lat = 1;

    // Redirect in REQ with grant held low; queue holds two entries.
    do_reset();
    repeat (3) step();
    step();
    gnt_en = 1'b0;
    step();
    check("rq_req",       {31'b0, instr_req},     32'd1);
    check("rq_addr",      instr_addr,             32'h8);
    check("rq_valid_pre", {31'b0, valid_if},      32'd1);
    pc_src = 1'b1;
    pc_new = 32'h200;
    #1;
    check("rq_valid_redir", {31'b0, valid_if},    32'd0);
    step();
    pc_src = 1'b0;
    gnt_en = 1'b1;
    #1;
    check("rq_req_held",  {31'b0, instr_req},     32'd1);
    check("rq_new_addr",  instr_addr,             32'h200);
    check("rq_flushed",   {31'b0, valid_if},      32'd0);
    wait_valid("rq", 10);
    check("rq_first_pc",  pc_if,                  32'h200);

    // Bubble hides the head and does not pop it.
    stall_if  = 1'b0;
    bubble_if = 1'b1;
    #1;
    check("bub_valid",    {31'b0, valid_if},      32'd0);
    step();
    bubble_if = 1'b0;
    stall_if  = 1'b1;
    #1;
    check("bub_valid_after", {31'b0, valid_if},   32'd1);
    check("bub_head_kept", pc_if,                 32'h200);

    // Fetch address wrap.
    start_at(32'hFFFF_FFFC);
    check("wrap_addr",    instr_addr,             32'hFFFF_FFFC);
    step();
    step();
    check("wrap_next_addr", instr_addr,           32'h0);
    check("wrap_pc",      pc_if,                  32'hFFFF_FFFC);
    check("wrap_pc4",     pc_plus4_if,            32'h0);

    // JAL fetched at 0x40.
    start_at(32'h40);
    check("jal_addr",     instr_addr,             32'h40);
    step();
    step();
    check("jal_valid",    {31'b0, valid_if},      32'd1);
    check("jal_pc",       pc_if,                  32'h40);
    check("jal_instr",    instr_if,               32'h0100_006F);
`ifdef IF_JAL_PREDICT_EN
    check("jal_next_addr", instr_addr,            32'h50);
    check("jal_pred",     {31'b0, pred_taken_if}, 32'd1);
`else
    check("jal_next_addr", instr_addr,            32'h44);
    check("jal_pred",     {31'b0, pred_taken_if}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/if_prefetch.md
Name: if_prefetch

Overview:
- Parametrised successor to the IF stage.
- Owns the fetch PC and drives a request/grant/response instruction-memory port that tolerates variable latency.
- Buffers returned instructions in a DEPTH-entry prefetch queue that the ID stage drains, so memory latency is decoupled from pipeline stalls.
- Handles redirects from EX (pc_src/pc_new), stall and bubble, and squashes in-flight fetches from the wrong path.

Parameters:
WIDTH, 32, address/instruction width
DEPTH, 4, prefetch queue entries (power of 2, >=2)
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-low reset (rst==0 resets on the clock edge)
stall_if  in  1  ID not accepting; hold queue head
bubble_if  in  1  present a bubble this cycle; valid_if forced 0, no pop
pc_src  in  1  redirect request from EX
pc_new  in  WIDTH  redirect target
instr_req  out  1  memory request
instr_addr  out  WIDTH  request address (word aligned)
instr_gnt  in  1  request accepted this cycle
instr_rvalid  in  1  response data valid
instr_rdata  in  WIDTH  response instruction
valid_if  out  1  queue head valid to ID
instr_if  out  WIDTH  head instruction
pc_if  out  WIDTH  head PC
pc_plus4_if  out  WIDTH  head PC + 4
pred_taken_if  out  1  head fetched via predicted JAL (0 without macro)

Behaviour:
- Reset (rst==0 at edge):
  - fetch_pc=RESET_PC, state=IDLE, queue empty (count=0).
  - instr_req=0, valid_if=0.
  - instr_if, pc_if, pc_plus4_if, pred_taken_if = 0.
  - Reset mid-transaction abandons any outstanding response; an instr_rvalid arriving after reset in IDLE is ignored.
- At most one outstanding memory transaction.
- FSM:
  - IDLE: go to REQ next cycle if count_next<DEPTH.
  - REQ:
    - instr_req=1, instr_addr=fetch_pc.
    - On instr_gnt: fetch_pc+=4 (mod 2^WIDTH), go to RESP.
    - Without instr_gnt: hold req; the address changes only on redirect.
  - RESP: on instr_rvalid, push {fetch-address, rdata, pred} to queue; then go to REQ if count_next<DEPTH, else IDLE.
  - DISCARD: wait for instr_rvalid, drop the data, then go to REQ (queue is empty after a flush).
- Redirect (pc_src=1), highest priority:
  - Queue flushed next cycle; fetch_pc<=pc_new with bits[1:0] cleared.
  - In RESP, or in REQ with instr_gnt the same cycle: go to DISCARD.
  - In REQ without instr_gnt: stay in REQ; instr_addr takes the new PC next cycle.
  - In IDLE/DISCARD: state unchanged except as described above.
  - instr_rvalid on the redirect cycle is dropped.
- Output:
  - valid_if = !empty && !bubble_if && !pc_src.
  - Head fields are driven combinationally from the queue head; they are 0 when empty.
  - pc_plus4_if = head pc + 4 (wraps).
  - Pop when valid_if && !stall_if.
- Push and pop in the same cycle are allowed; count is unchanged.
- A push into a full queue cannot occur, because a slot is reserved before the request issues.
- Minimum latency: gnt at cycle t, rvalid at t+1, valid_if at t+2.
- Sustained throughput with 1-cycle memory is 1 instr per 2 cycles; the queue absorbs stalls.

Optional Feature:
- Macro: IF_JAL_PREDICT_EN.
- Defined:
  - On an accepted instr_rvalid (RESP, no redirect) with rdata[6:0]==7'b1101111, fetch_pc <= response PC + sign-extended J-immediate {rdata[31],rdata[19:12],rdata[20],rdata[30:21],1'b0}.
  - The entry is pushed with pred=1, so pred_taken_if=1 at the head.
  - EX still redirects on JAL as normal; a redirect to the same target is harmless.
- Undefined: fully sequential fetch, pred_taken_if tied 0.

Test Plan:
- Reset release, 1-cycle memory returning 0x00000013 -> first instr_req with addr 0x0 one cycle after rst deasserts; valid_if=1, pc_if=0x0, pc_plus4_if=0x4 two cycles after gnt.
- stall_if=1 for 20 cycles, DEPTH=4 -> exactly 4 entries (pc 0x0,0x4,0x8,0xC) queued, instr_req stays 0; on release, entries drain in order, one per cycle.
- pc_src=1, pc_new=0x103 while in RESP -> next rvalid dropped (DISCARD); next request addr=0x100; no stale entry ever reaches valid_if.
- Redirect while in REQ with gnt held low, pc_new=0x200 -> instr_addr changes 0x8->0x200 without deasserting instr_req; first valid pc_if=0x200.
- bubble_if=1 with non-empty queue -> valid_if=0 that cycle, head unchanged next cycle; fetch_pc=0xFFFFFFFC -> next addr wraps to 0x0.
- With IF_JAL_PREDICT_EN: rdata=0x0100006F (jal x0,+16) fetched at 0x40 -> next instr_addr=0x50, pred_taken_if=1 for that entry; without the macro next addr=0x44, pred_taken_if=0.
